// File: rtl/mmc1_pkg.sv
// Shared constants for the MMC1 serial loader and register bank.
// Latency: none (package only).
// Backpressure: none (package only).
package mmc1_pkg;

    // Target register selects, taken from {A14,A13} on the committing write.
    localparam logic [1:0] SEL_CONTROL = 2'b00;
    localparam logic [1:0] SEL_CHR0    = 2'b01;
    localparam logic [1:0] SEL_CHR1    = 2'b10;
    localparam logic [1:0] SEL_PRG     = 2'b11;

    // Serial writes needed for one register commit.
    localparam int MMC1_SHIFT_LEN = 5;

    // The register bank ORs this into control when CTRL_RESET pulses (PRG mode 3).
    localparam logic [4:0] CTRL_RESET_MASK = 5'b01100;

endpackage

// File: rtl/mmc1_commit_buf.sv
// Two-deep commit buffer (output slot + hold slot) between shifter and register bank.
// Latency: a commit reaches the output in the same M2 falling edge when the output slot is free.
// Backpressure: valid/ready; a third outstanding commit is dropped and OVERRUN latches.
//
// Ports: m2_i (state updates on falling edge), rst_i (sync, active-high),
//        commit_vld_i/commit_sel_i/commit_dat_i (new value), rdy_i (bank ready),
//        vld_o/sel_o/dat_o (presented value), overrun_o (sticky drop flag).
module mmc1_commit_buf #(
    parameter int DW = 5
) (
    input  logic          m2_i,
    input  logic          rst_i,
    input  logic          commit_vld_i,
    input  logic [1:0]    commit_sel_i,
    input  logic [DW-1:0] commit_dat_i,
    input  logic          rdy_i,
    output logic          vld_o,
    output logic [1:0]    sel_o,
    output logic [DW-1:0] dat_o,
    output logic          overrun_o
);

    logic          out_vld_q, out_vld_d;
    logic [1:0]    out_sel_q, out_sel_d;
    logic [DW-1:0] out_dat_q, out_dat_d;
    logic          hold_vld_q, hold_vld_d;
    logic [1:0]    hold_sel_q, hold_sel_d;
    logic [DW-1:0] hold_dat_q, hold_dat_d;
    logic          ovr_q, ovr_d;
    logic          xfer;
    logic          out_free;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_sel_d  = out_sel_q;
        out_dat_d  = out_dat_q;
        hold_vld_d = hold_vld_q;
        hold_sel_d = hold_sel_q;
        hold_dat_d = hold_dat_q;
        ovr_d      = ovr_q;
        xfer       = out_vld_q && rdy_i;
        // The output slot can take a new value if it is empty or handing off this edge.
        out_free   = !out_vld_q || xfer;

        if (commit_vld_i) begin
            if (out_free) begin
                out_vld_d = 1'b1;
                if (hold_vld_q) begin
                    // Keep ordering: older held value advances, new one waits in hold.
                    out_sel_d  = hold_sel_q;
                    out_dat_d  = hold_dat_q;
                    hold_sel_d = commit_sel_i;
                    hold_dat_d = commit_dat_i;
                end else begin
                    out_sel_d = commit_sel_i;
                    out_dat_d = commit_dat_i;
                end
            end else if (!hold_vld_q) begin
                hold_vld_d = 1'b1;
                hold_sel_d = commit_sel_i;
                hold_dat_d = commit_dat_i;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (xfer) begin
            if (hold_vld_q) begin
                out_sel_d  = hold_sel_q;
                out_dat_d  = hold_dat_q;
                hold_vld_d = 1'b0;
            end else begin
                out_vld_d = 1'b0;
            end
        end
    end

    always_ff @(negedge m2_i) begin
        if (rst_i) begin
            out_vld_q  <= 1'b0;
            out_sel_q  <= '0;
            out_dat_q  <= '0;
            hold_vld_q <= 1'b0;
            hold_sel_q <= '0;
            hold_dat_q <= '0;
            ovr_q      <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_sel_q  <= out_sel_d;
            out_dat_q  <= out_dat_d;
            hold_vld_q <= hold_vld_d;
            hold_sel_q <= hold_sel_d;
            hold_dat_q <= hold_dat_d;
            ovr_q      <= ovr_d;
        end
    end

    assign vld_o     = out_vld_q;
    assign sel_o     = out_sel_q;
    assign dat_o     = out_dat_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/mmc1_serial_loader.sv
// MMC1 serial write loader: filters CPU writes, shifts D0 into a 5-bit value, commits by {A14,A13}.
// Latency: SHIFT_CNT/LOAD_BUSY/CTRL_RESET and a free-slot commit all update on the write's M2 falling edge.
// Backpressure: REG_VALID/REG_READY into a two-deep buffer; excess commits dropped, OVERRUN sticky.
//
// Optional feature: MMC1_CONSEC_FILTER_EN ignores a write on the cycle right after another raw write
// (RMW second write). Undefined: every raw write is accepted.
// Ports: CPU_M2 (clock, falling edge), RESET (sync, active-high), nCPU_ROMSEL, nCPU_RW, CPU_A14,
//        CPU_A13, CPU_D0, CPU_D7 (CPU bus); REG_READY/REG_VALID/REG_SEL/REG_DATA (bank handshake);
//        CTRL_RESET (one-cycle D7 pulse), LOAD_BUSY, SHIFT_CNT, OVERRUN (status).
module mmc1_serial_loader
    import mmc1_pkg::*;
#(
    parameter int SHIFT_LEN = MMC1_SHIFT_LEN
) (
    input  logic                 CPU_M2,
    input  logic                 RESET,
    input  logic                 nCPU_ROMSEL,
    input  logic                 nCPU_RW,
    input  logic                 CPU_A14,
    input  logic                 CPU_A13,
    input  logic                 CPU_D0,
    input  logic                 CPU_D7,
    input  logic                 REG_READY,
    output logic                 REG_VALID,
    output logic [1:0]           REG_SEL,
    output logic [SHIFT_LEN-1:0] REG_DATA,
    output logic                 CTRL_RESET,
    output logic                 LOAD_BUSY,
    output logic [2:0]           SHIFT_CNT,
    output logic                 OVERRUN
);

    localparam logic [2:0] CNT_LAST = 3'(SHIFT_LEN - 1);

    logic                 raw_wr;
    logic                 acc_wr;
    logic [SHIFT_LEN-1:0] shreg_q, shreg_d;
    logic [SHIFT_LEN-1:0] shifted;
    logic [2:0]           cnt_q, cnt_d;
    logic                 ctrl_q, ctrl_d;
    logic                 commit_vld;

    assign raw_wr = !nCPU_ROMSEL && !nCPU_RW;

`ifdef MMC1_CONSEC_FILTER_EN
    logic prev_wr_q;

    always_ff @(negedge CPU_M2) begin
        if (RESET) prev_wr_q <= 1'b0;
        else       prev_wr_q <= raw_wr;
    end

    // Second half of a read-modify-write lands the cycle after the first: drop it.
    assign acc_wr = raw_wr && !prev_wr_q;
`else
    assign acc_wr = raw_wr;
`endif

    // New bits enter at the top so the first write ends up at bit 0.
    assign shifted = {CPU_D0, shreg_q[SHIFT_LEN-1:1]};

    always_comb begin
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        ctrl_d     = 1'b0;
        commit_vld = 1'b0;
        if (acc_wr) begin
            if (CPU_D7) begin
                // D7 wins even on what would have been the final write.
                shreg_d = '0;
                cnt_d   = '0;
                ctrl_d  = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                commit_vld = 1'b1;
                shreg_d    = '0;
                cnt_d      = '0;
            end else begin
                shreg_d = shifted;
                cnt_d   = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(negedge CPU_M2) begin
        if (RESET) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            ctrl_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    mmc1_commit_buf #(
        .DW (SHIFT_LEN)
    ) u_commit_buf (
        .m2_i         (CPU_M2),
        .rst_i        (RESET),
        .commit_vld_i (commit_vld),
        .commit_sel_i ({CPU_A14, CPU_A13}),
        .commit_dat_i (shifted),
        .rdy_i        (REG_READY),
        .vld_o        (REG_VALID),
        .sel_o        (REG_SEL),
        .dat_o        (REG_DATA),
        .overrun_o    (OVERRUN)
    );

    assign CTRL_RESET = ctrl_q;
    assign SHIFT_CNT  = cnt_q;
    assign LOAD_BUSY  = (cnt_q != 3'd0);

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// Self-checking bench for mmc1_serial_loader: directed steps from the test plan plus random traffic.
// Latency: outputs sampled 1 time unit after each M2 falling edge.
// Backpressure: REG_READY driven directly per step; reference model is a bit queue plus a pending-value queue.
module tb_mmc1_serial_loader;

    localparam int N = 5;

    logic         CPU_M2;
    logic         RESET;
    logic         nCPU_ROMSEL;
    logic         nCPU_RW;
    logic         CPU_A14;
    logic         CPU_A13;
    logic         CPU_D0;
    logic         CPU_D7;
    logic         REG_READY;
    logic         REG_VALID;
    logic [1:0]   REG_SEL;
    logic [N-1:0] REG_DATA;
    logic         CTRL_RESET;
    logic         LOAD_BUSY;
    logic [2:0]   SHIFT_CNT;
    logic         OVERRUN;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic       m_bits[$];   // D0 values received since the last clear, oldest first
    logic [6:0] m_pend[$];   // {sel,data} values committed but not yet taken by the bank
    logic       m_ovr;
    logic       m_ctrl;
`ifdef MMC1_CONSEC_FILTER_EN
    logic       m_prev;
`endif

    mmc1_serial_loader #(.SHIFT_LEN(N)) dut (
        .CPU_M2      (CPU_M2),
        .RESET       (RESET),
        .nCPU_ROMSEL (nCPU_ROMSEL),
        .nCPU_RW     (nCPU_RW),
        .CPU_A14     (CPU_A14),
        .CPU_A13     (CPU_A13),
        .CPU_D0      (CPU_D0),
        .CPU_D7      (CPU_D7),
        .REG_READY   (REG_READY),
        .REG_VALID   (REG_VALID),
        .REG_SEL     (REG_SEL),
        .REG_DATA    (REG_DATA),
        .CTRL_RESET  (CTRL_RESET),
        .LOAD_BUSY   (LOAD_BUSY),
        .SHIFT_CNT   (SHIFT_CNT),
        .OVERRUN     (OVERRUN)
    );

    initial CPU_M2 = 1'b0;
    always #5 CPU_M2 = ~CPU_M2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One M2 cycle: drive inputs, let the falling edge happen, advance the model, compare.
    task automatic step(input logic rst, input logic rs_n, input logic rw_n, input logic a14,
                        input logic a13, input logic d0, input logic d7, input logic rdy);
        logic       raw;
        logic       acc;
        logic       have_commit;
        logic [4:0] val;
        logic [6:0] commit;
        RESET = rst; nCPU_ROMSEL = rs_n; nCPU_RW = rw_n;
        CPU_A14 = a14; CPU_A13 = a13; CPU_D0 = d0; CPU_D7 = d7; REG_READY = rdy;
        @(negedge CPU_M2);
        #1;
        raw         = !rs_n && !rw_n;
        have_commit = 1'b0;
        commit      = '0;
        if (rst) begin
            m_bits.delete();
            m_pend.delete();
            m_ovr  = 1'b0;
            m_ctrl = 1'b0;
`ifdef MMC1_CONSEC_FILTER_EN
            m_prev = 1'b0;
`endif
        end else begin
            acc = raw;
`ifdef MMC1_CONSEC_FILTER_EN
            acc    = raw && !m_prev;
            m_prev = raw;
`endif
            m_ctrl = 1'b0;
            if (acc && d7) begin
                m_bits.delete();
                m_ctrl = 1'b1;
            end else if (acc) begin
                m_bits.push_back(d0);
                if (m_bits.size() == N) begin
                    val = '0;
                    for (int i = 0; i < N; i++) val[i] = m_bits[i];
                    commit      = {a14, a13, val};
                    have_commit = 1'b1;
                    m_bits.delete();
                end
            end
            if (m_pend.size() > 0 && rdy) void'(m_pend.pop_front());
            if (have_commit) begin
                if (m_pend.size() < 2) m_pend.push_back(commit);
                else                   m_ovr = 1'b1;
            end
        end
        chk("valid", {31'd0, REG_VALID}, {31'd0, m_pend.size() != 0});
        chk("shift_cnt", {29'd0, SHIFT_CNT}, m_bits.size());
        chk("load_busy", {31'd0, LOAD_BUSY}, {31'd0, m_bits.size() != 0});
        chk("ctrl_reset", {31'd0, CTRL_RESET}, {31'd0, m_ctrl});
        chk("overrun", {31'd0, OVERRUN}, {31'd0, m_ovr});
        if (m_pend.size() != 0) begin
            chk("reg_sel", {30'd0, REG_SEL}, {30'd0, m_pend[0][6:5]});
            chk("reg_data", {27'd0, REG_DATA}, {27'd0, m_pend[0][4:0]});
        end
    endtask

    task automatic wr(input logic a14, input logic a13, input logic d0, input logic d7, input logic rdy);
        step(1'b0, 1'b0, 1'b0, a14, a13, d0, d7, rdy);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Five spaced writes delivering val (bit 0 first) to register {a14,a13}.
    task automatic load5(input logic a14, input logic a13, input logic [4:0] val, input logic rdy);
        for (int i = 0; i < N; i++) begin
            wr(a14, a13, val[i], 1'b0, rdy);
            if (i != N - 1) idle(rdy);
        end
    endtask

    initial begin
        m_ovr = 1'b0; m_ctrl = 1'b0;
`ifdef MMC1_CONSEC_FILTER_EN
        m_prev = 1'b0;
`endif
        RESET = 1'b1; nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1; CPU_A14 = 1'b0; CPU_A13 = 1'b0;
        CPU_D0 = 1'b0; CPU_D7 = 1'b0; REG_READY = 1'b0;

        // Reset state.
        do_reset();
        do_reset();
        chk("rst_sel", {30'd0, REG_SEL}, 32'd0);
        chk("rst_data", {27'd0, REG_DATA}, 32'd0);

        // $E000 with D0 = 1,0,1,1,0 -> PRG, 01101.
        load5(1'b1, 1'b1, 5'b01101, 1'b1);
        chk("e000_sel", {30'd0, REG_SEL}, 32'd3);
        chk("e000_data", {27'd0, REG_DATA}, 32'b01101);
        idle(1'b1);
        chk("e000_drained", {31'd0, REG_VALID}, 32'd0);

        // Three writes then D7 -> pulse, count cleared; then $8000 all ones.
        for (int i = 0; i < 3; i++) begin wr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); idle(1'b1); end
        wr(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("d7_pulse", {31'd0, CTRL_RESET}, 32'd1);
        chk("d7_cnt", {29'd0, SHIFT_CNT}, 32'd0);
        idle(1'b1);
        chk("d7_pulse_end", {31'd0, CTRL_RESET}, 32'd0);
        wr(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        wr(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("d7_second_pulse", {31'd0, CTRL_RESET}, 32'd1);
        idle(1'b1);
        load5(1'b0, 1'b0, 5'b11111, 1'b0);
        chk("8000_sel", {30'd0, REG_SEL}, 32'd0);
        chk("8000_data", {27'd0, REG_DATA}, 32'b11111);
        idle(1'b1);

        // Back-to-back writes: the second one is filtered only when the filter is built in.
        wr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        wr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef MMC1_CONSEC_FILTER_EN
        chk("consec_cnt", {29'd0, SHIFT_CNT}, 32'd1);
`else
        chk("consec_cnt", {29'd0, SHIFT_CNT}, 32'd2);
`endif
        do_reset();

        // Stalled bank: values 1,2,3 -> 1 out, 2 held, 3 dropped.
        load5(1'b0, 1'b0, 5'd1, 1'b0); idle(1'b0);
        load5(1'b0, 1'b0, 5'd2, 1'b0); idle(1'b0);
        load5(1'b0, 1'b0, 5'd3, 1'b0);
        chk("stall_out", {27'd0, REG_DATA}, 32'd1);
        chk("stall_ovr", {31'd0, OVERRUN}, 32'd1);
        idle(1'b1);
        chk("stall_next", {27'd0, REG_DATA}, 32'd2);
        chk("stall_next_vld", {31'd0, REG_VALID}, 32'd1);
        idle(1'b1);
        chk("stall_empty", {31'd0, REG_VALID}, 32'd0);
        chk("stall_ovr_sticky", {31'd0, OVERRUN}, 32'd1);

        // Reset mid-sequence, then $A000 with 0,0,0,0,1.
        for (int i = 0; i < 4; i++) begin wr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); idle(1'b0); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("midrst_cnt", {29'd0, SHIFT_CNT}, 32'd0);
        chk("midrst_ovr", {31'd0, OVERRUN}, 32'd0);
        load5(1'b0, 1'b1, 5'b10000, 1'b0);
        chk("a000_sel", {30'd0, REG_SEL}, 32'd1);
        chk("a000_data", {27'd0, REG_DATA}, 32'b10000);
        idle(1'b1);

        // Reads and non-ROM writes leave everything alone.
        wr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); idle(1'b1);
        wr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        end
        chk("noacc_cnt", {29'd0, SHIFT_CNT}, 32'd2);
        chk("noacc_ctrl", {31'd0, CTRL_RESET}, 32'd0);
        chk("noacc_vld", {31'd0, REG_VALID}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 7) == 0,
                 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmc1_serial_loader.md
# mmc1_serial_loader

Upstream front end of the MMC1 register bank. It samples CPU cartridge-space writes once per CPU cycle and suppresses the second write of a back-to-back read-modify-write pair. It assembles the 1-bit serial writes into 5-bit register values and hands each completed value, plus its target-register select, to the register bank over a valid/ready handshake. It also flags D7 reset writes so the register bank can force PRG mode 3.

## Interface
Parameters:
- SHIFT_LEN, 5, number of serial writes per register commit.

Ports:
- CPU_M2  in  1  clock; all state updates on the falling edge of M2.
- RESET  in  1  synchronous, active-high reset.
- nCPU_ROMSEL  in  1  low = $8000–$FFFF access.
- nCPU_RW  in  1  low = CPU write.
- CPU_A14, CPU_A13  in  1 each  register select.
- CPU_D0  in  1  serial data bit.
- CPU_D7  in  1  shift-register reset request.
- REG_READY  in  1  register bank accepts the presented value.
- REG_VALID  out  1  REG_SEL/REG_DATA hold a completed value.
- REG_SEL  out  2  {A14,A13} latched at the 5th write: 00 control, 01 CHR0, 10 CHR1, 11 PRG.
- REG_DATA  out  5  assembled value; the first write is at bit 0.
- CTRL_RESET  out  1  one-cycle pulse; register bank ORs 5'b01100 into control.
- LOAD_BUSY  out  1  SHIFT_CNT != 0.
- SHIFT_CNT  out  3  writes accumulated, 0..4.
- OVERRUN  out  1  sticky; a commit was dropped.

## Operation
- Raw write: wr = !nCPU_ROMSEL && !nCPU_RW at the M2 falling edge. prev_wr registers raw wr every cycle.
- Accepted write: wr && !prev_wr when the filter is compiled in (see Configuration). Otherwise any wr is accepted.
- Accepted write with D7=1:
  - Clear the shift register and SHIFT_CNT.
  - Pulse CTRL_RESET.
  - Leave REG_VALID, the hold slot and OVERRUN untouched.
  - D7 takes priority over any D0 shift, including on what would be the 5th write.
- Accepted write with D7=0, SHIFT_CNT < 4: shift reg = {D0, shreg[4:1]}; SHIFT_CNT++.
- Accepted write with D7=0, SHIFT_CNT == 4: commit value {D0, shreg[4:1]} and sel {A14,A13}; SHIFT_CNT = 0.
- Commit buffer, consisting of an output slot plus a one-entry hold slot:
  - Transfer occurs when REG_VALID && REG_READY at an edge.
  - Output slot is empty or transferring: a commit loads the output slot, unless the hold slot is full. In that case the hold slot moves to output and the commit enters hold.
  - Output slot busy and hold empty: the commit goes to hold.
  - Output slot busy and hold full: the commit is dropped and OVERRUN is set.
  - Transfer with no commit and hold full: hold moves to output and REG_VALID stays 1. Transfer with no commit and hold empty: REG_VALID goes to 0.
- Non-write cycles, and any cycle with nCPU_ROMSEL=1: no shift-register change.

## Timing
- Reset values: REG_VALID 0, REG_SEL 00, REG_DATA 00000, CTRL_RESET 0, LOAD_BUSY 0, SHIFT_CNT 0, OVERRUN 0; prev_wr, shift register and hold slot all cleared.
- RESET mid-sequence discards partial bits and any pending or held values. RESET overrides a simultaneous write.
- Latency: an accepted write updates SHIFT_CNT and LOAD_BUSY at the same M2 falling edge. The 5th write raises REG_VALID at that edge when the output slot is free.
- CTRL_RESET is high for exactly one cycle after the D7 write edge. Two D7 writes separated by a cycle give two pulses.
- REG_SEL and REG_DATA are stable while REG_VALID=1 and REG_READY=0.
- The commit buffer is never more than 2 deep. OVERRUN is cleared only by RESET.

## Configuration
- MMC1_CONSEC_FILTER_EN defined: a write in the cycle immediately following another raw write is ignored entirely. It does not shift, does not trigger a D7 reset, and does not commit. This matches RMW behaviour on hardware.
- Undefined: every raw write is accepted. prev_wr logic is removed.

## Structure
- Shared package mmc1_pkg holds:
  - SEL_CONTROL = 2'b00, SEL_CHR0 = 2'b01, SEL_CHR1 = 2'b10, SEL_PRG = 2'b11.
  - MMC1_SHIFT_LEN = 5.
  - CTRL_RESET_MASK = 5'b01100.
- Sub-module mmc1_commit_buf contains the output slot, hold slot, handshake and OVERRUN. The top contains filter, shift register and counter.

## Test plan
- Five non-consecutive writes to $E000 with D0 = 1,0,1,1,0 and REG_READY=1 -> REG_VALID pulse, REG_SEL=11, REG_DATA=01101, SHIFT_CNT back to 0.
- Three writes, then a write with D7=1 -> CTRL_RESET high for one cycle, SHIFT_CNT=0. The next five writes to $8000 with D0 all 1 -> SEL=00, DATA=11111.
- Writes D0=1 then D0=0 on consecutive cycles -> with the filter SHIFT_CNT=1 and shreg[4]=1; without the filter SHIFT_CNT=2.
- REG_READY=0 and three full commits (values 1, 2, 3) -> output holds 1, hold holds 2, 3 is dropped, OVERRUN=1. Raise REG_READY -> 1 transfers and 2 is presented the next cycle.
- RESET asserted after four writes -> all outputs return to reset values. Five further writes to $A000 with D0 = 0,0,0,0,1 -> SEL=01, DATA=10000.
- Read cycles at $8000 (nCPU_RW=1) and writes with nCPU_ROMSEL=1 -> SHIFT_CNT, REG_VALID and CTRL_RESET unchanged.
